// File: rtl/neureka_binconv_column_bitserial.sv
// Bit-serial binconv column: reduces masked activation x weight-bit lanes per beat and
// accumulates MSB-first bit-planes into a signed partial result buffered in a small FIFO.
module neureka_binconv_column_bitserial #(
    parameter int unsigned COLUMN_SIZE    = 9,
    parameter int unsigned QA_IN          = 8,
    parameter int unsigned MAX_WBITS      = 8,
    parameter int unsigned OUT_FIFO_DEPTH = 2,
    parameter int unsigned PIPELINE       = 1,
    localparam int unsigned SUM_W = QA_IN + $clog2(COLUMN_SIZE),
    localparam int unsigned ACC_W = SUM_W + MAX_WBITS + 1,
    localparam int unsigned CNT_W = $clog2(MAX_WBITS + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         clear_i,
    input  logic                         act_valid_i,
    output logic                         act_ready_o,
    input  logic [COLUMN_SIZE*QA_IN-1:0] act_data_i,
    input  logic                         wgt_valid_i,
    output logic                         wgt_ready_o,
    input  logic [COLUMN_SIZE-1:0]       wgt_data_i,
    input  logic [CNT_W-1:0]             wbits_i,
    input  logic                         signed_i,
    input  logic                         weight_offset_i,
    input  logic [COLUMN_SIZE-1:0]       enable_mask_i,
    output logic                         pres_valid_o,
    input  logic                         pres_ready_i,
    output logic [ACC_W-1:0]             pres_data_o,
    output logic                         busy_o
);

    localparam int unsigned PTR_W  = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(OUT_FIFO_DEPTH + 1);

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   plane_cnt_q, plane_cnt_d;
    logic [CNT_W-1:0]   wbits_lat_q, wbits_lat_d;
    logic               signed_lat_q, signed_lat_d;
    logic [CNT_W-1:0]   wbits_clamped, cur_wbits;
    logic               cur_signed, first_plane, last_plane;
    logic               flush, credit_ok, fire, inflight, pipe_busy;
    logic [SUM_W-1:0]   colsum;
    logic               s1_neg;

    logic               s2_valid, s2_first, s2_neg, s2_last;
    logic [SUM_W-1:0]   s2_sum;
    logic signed [ACC_W-1:0] acc_q, acc_next, sum_ext;

    logic [ACC_W-1:0]   fifo_mem [OUT_FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [FCNT_W-1:0]  fifo_cnt_q;
    logic               push, pop;

    assign flush = !rst_ni || clear_i;

    always_comb begin
        if (wbits_i == '0) begin
            wbits_clamped = CNT_W'(1);
        end else if (wbits_i > CNT_W'(MAX_WBITS)) begin
            wbits_clamped = CNT_W'(MAX_WBITS);
        end else begin
            wbits_clamped = wbits_i;
        end
    end

    // In IDLE the beat being offered is the first plane, so it uses the live wbits/signed.
    assign cur_wbits   = (state_q == IDLE) ? wbits_clamped : wbits_lat_q;
    assign cur_signed  = (state_q == IDLE) ? signed_i : signed_lat_q;
    assign first_plane = (plane_cnt_q == '0);
    assign last_plane  = (plane_cnt_q == cur_wbits - CNT_W'(1));
    assign s1_neg      = first_plane && cur_signed && (cur_wbits > CNT_W'(1));

    // A new result may only start if a FIFO slot is guaranteed once it completes.
    assign credit_ok = (state_q == ACCUM) ||
                       (({1'b0, fifo_cnt_q} + (FCNT_W+1)'(inflight)) < (FCNT_W+1)'(OUT_FIFO_DEPTH));

    assign fire = rst_ni && !clear_i && enable_i && act_valid_i &&
                  (wgt_valid_i || weight_offset_i) && credit_ok;

    assign wgt_ready_o = fire;
    assign act_ready_o = fire && last_plane;

    always_comb begin
        colsum = '0;
        for (int unsigned ii = 0; ii < COLUMN_SIZE; ii++) begin
            if (enable_mask_i[ii] && (weight_offset_i || wgt_data_i[ii])) begin
                colsum = colsum + SUM_W'(act_data_i[ii*QA_IN +: QA_IN]);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        plane_cnt_d  = plane_cnt_q;
        wbits_lat_d  = wbits_lat_q;
        signed_lat_d = signed_lat_q;
        if (fire) begin
            plane_cnt_d = last_plane ? '0 : plane_cnt_q + CNT_W'(1);
            if (state_q == IDLE) begin
                wbits_lat_d  = wbits_clamped;
                signed_lat_d = signed_i;
                if (!last_plane) begin
                    state_d = ACCUM;
                end
            end else if (last_plane) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            state_q      <= IDLE;
            plane_cnt_q  <= '0;
            wbits_lat_q  <= CNT_W'(1);
            signed_lat_q <= 1'b0;
        end else if (enable_i) begin
            state_q      <= state_d;
            plane_cnt_q  <= plane_cnt_d;
            wbits_lat_q  <= wbits_lat_d;
            signed_lat_q <= signed_lat_d;
        end
    end

    generate
        if (PIPELINE != 0) begin : g_pipe
            logic             pipe_valid_q, pipe_first_q, pipe_neg_q, pipe_last_q;
            logic [SUM_W-1:0] pipe_sum_q;

            always_ff @(posedge clk_i) begin
                if (flush) begin
                    pipe_valid_q <= 1'b0;
                    pipe_first_q <= 1'b0;
                    pipe_neg_q   <= 1'b0;
                    pipe_last_q  <= 1'b0;
                    pipe_sum_q   <= '0;
                end else if (enable_i) begin
                    pipe_valid_q <= fire;
                    if (fire) begin
                        pipe_first_q <= first_plane;
                        pipe_neg_q   <= s1_neg;
                        pipe_last_q  <= last_plane;
                        pipe_sum_q   <= colsum;
                    end
                end
            end

            assign s2_valid  = pipe_valid_q;
            assign s2_first  = pipe_first_q;
            assign s2_neg    = pipe_neg_q;
            assign s2_last   = pipe_last_q;
            assign s2_sum    = pipe_sum_q;
            assign inflight  = pipe_valid_q && pipe_last_q;
            assign pipe_busy = pipe_valid_q;
        end else begin : g_comb
            assign s2_valid  = fire;
            assign s2_first  = first_plane;
            assign s2_neg    = s1_neg;
            assign s2_last   = last_plane;
            assign s2_sum    = colsum;
            assign inflight  = 1'b0;
            assign pipe_busy = 1'b0;
        end
    endgenerate

    assign sum_ext  = $signed({{(ACC_W-SUM_W){1'b0}}, s2_sum});
    assign acc_next = (s2_first ? ACC_W'(0) : (acc_q <<< 1)) + (s2_neg ? -sum_ext : sum_ext);

    always_ff @(posedge clk_i) begin
        if (flush) begin
            acc_q <= '0;
        end else if (enable_i && s2_valid) begin
            acc_q <= acc_next;
        end
    end

    assign push = enable_i && s2_valid && s2_last;
    assign pop  = enable_i && pres_valid_o && pres_ready_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (flush) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!flush && push) begin
            fifo_mem[wr_ptr_q] <= acc_next;
        end
    end

    assign pres_valid_o = (fifo_cnt_q != '0);
    assign pres_data_o  = pres_valid_o ? fifo_mem[rd_ptr_q] : '0;
    assign busy_o       = (state_q != IDLE) || pipe_busy || (fifo_cnt_q != '0);

endmodule

// File: tb/tb_neureka_binconv_column_bitserial.sv
// Directed and randomized checks of the bit-serial binconv column against a
// weight-value reference model (result = sum of masked act * integer weight).
module tb_neureka_binconv_column_bitserial;

    localparam int unsigned CS    = 9;
    localparam int unsigned QA    = 8;
    localparam int unsigned MW    = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned PIPE  = 1;
    localparam int unsigned SUM_W = QA + $clog2(CS);
    localparam int unsigned ACC_W = SUM_W + MW + 1;
    localparam int unsigned CNT_W = $clog2(MW + 1);
    localparam int          NRAND = 25;

    typedef logic [CS-1:0]    plane_t;
    typedef logic [CS*QA-1:0] act_t;

    logic             clk_i = 1'b0;
    logic             rst_ni, enable_i, clear_i;
    logic             act_valid_i, act_ready_o;
    act_t             act_data_i;
    logic             wgt_valid_i, wgt_ready_o;
    plane_t           wgt_data_i;
    logic [CNT_W-1:0] wbits_i;
    logic             signed_i, weight_offset_i;
    plane_t           enable_mask_i;
    logic             pres_valid_o, pres_ready_i;
    logic [ACC_W-1:0] pres_data_o;
    logic             busy_o;

    neureka_binconv_column_bitserial #(
        .COLUMN_SIZE   (CS),
        .QA_IN         (QA),
        .MAX_WBITS     (MW),
        .OUT_FIFO_DEPTH(DEPTH),
        .PIPELINE      (PIPE)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .clear_i        (clear_i),
        .act_valid_i    (act_valid_i),
        .act_ready_o    (act_ready_o),
        .act_data_i     (act_data_i),
        .wgt_valid_i    (wgt_valid_i),
        .wgt_ready_o    (wgt_ready_o),
        .wgt_data_i     (wgt_data_i),
        .wbits_i        (wbits_i),
        .signed_i       (signed_i),
        .weight_offset_i(weight_offset_i),
        .enable_mask_i  (enable_mask_i),
        .pres_valid_o   (pres_valid_o),
        .pres_ready_i   (pres_ready_i),
        .pres_data_o    (pres_data_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int     checks = 0;
    int     errors = 0;
    longint exp_q[$];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_wbits(input logic [CNT_W-1:0] wb);
        if (wb == 0) return 1;
        if (int'(wb) > MW) return MW;
        return int'(wb);
    endfunction

    function automatic act_t act_all(input logic [QA-1:0] v);
        act_t a;
        for (int ln = 0; ln < CS; ln++) a[ln*QA +: QA] = v;
        return a;
    endfunction

    // Each lane's weight is the integer encoded by its bits across planes (plane 0 = MSB).
    function automatic longint model(input act_t act, input plane_t pl[MW], input logic [CNT_W-1:0] wb,
                                     input logic sg, input plane_t mask, input logic off);
        int     we;
        longint r;
        longint w;
        we = eff_wbits(wb);
        r  = 0;
        for (int ln = 0; ln < CS; ln++) begin
            w = 0;
            for (int p = 0; p < we; p++) begin
                if (off || pl[p][ln]) begin
                    if (p == 0 && sg && we > 1) w -= longint'(1) << (we - 1);
                    else                        w += longint'(1) << (we - 1 - p);
                end
            end
            if (mask[ln]) r += longint'(act[ln*QA +: QA]) * w;
        end
        return r;
    endfunction

    // Entered and left at posedge+1; holds the beat until it fires.
    task automatic do_beat(input act_t act, input plane_t w, input logic off, input plane_t mask,
                           input logic exp_last, input string tag);
        int n;
        n = 0;
        act_data_i      = act;
        wgt_data_i      = w;
        weight_offset_i = off;
        enable_mask_i   = mask;
        act_valid_i     = 1'b1;
        wgt_valid_i     = off ? 1'($urandom) : 1'b1;
        #1;
        while (wgt_ready_o !== 1'b1 && n < 100) begin
            @(posedge clk_i); #2;
            n++;
        end
        chk({tag, "_fire_in_time"}, (n < 100), 1);
        chk({tag, "_act_ready"}, act_ready_o, exp_last);
        @(posedge clk_i); #1;
        act_valid_i = 1'b0;
        wgt_valid_i = 1'b0;
    endtask

    task automatic send_result(input act_t act, input plane_t pl[MW], input logic [CNT_W-1:0] wb,
                               input logic sg, input plane_t mask, input logic off, input string tag);
        int we;
        we       = eff_wbits(wb);
        wbits_i  = wb;
        signed_i = sg;
        for (int p = 0; p < we; p++) begin
            do_beat(act, pl[p], off, mask, (p == we - 1), $sformatf("%s_p%0d", tag, p));
            if (p == 0) begin
                wbits_i  = CNT_W'($urandom);
                signed_i = 1'($urandom);
            end
        end
    endtask

    task automatic expect_result(input longint exp, input string tag);
        int n;
        n = 0;
        pres_ready_i = 1'b1;
        #1;
        while (pres_valid_o !== 1'b1 && n < 50) begin
            @(posedge clk_i); #2;
            n++;
        end
        chk({tag, "_valid"}, pres_valid_o, 1);
        chk({tag, "_data"}, $signed(pres_data_o), exp);
        @(posedge clk_i); #1;
        pres_ready_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        plane_t pl[MW];
        plane_t full;
        longint r1, r2, r3;
        logic [QA-1:0] a1, a2, a3;

        full = '1;
        foreach (pl[i]) pl[i] = '0;

        // reset, with upstream already offering data
        rst_ni = 1'b0; enable_i = 1'b1; clear_i = 1'b0;
        act_valid_i = 1'b1; wgt_valid_i = 1'b1; weight_offset_i = 1'b1;
        act_data_i = act_all(8'd1); wgt_data_i = '1; wbits_i = CNT_W'(1);
        signed_i = 1'b0; enable_mask_i = '1; pres_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_act_ready", act_ready_o, 0);
        chk("rst_wgt_ready", wgt_ready_o, 0);
        chk("rst_pres_valid", pres_valid_o, 0);
        chk("rst_pres_data", pres_data_o, 0);
        chk("rst_busy", busy_o, 0);
        act_valid_i = 1'b0; wgt_valid_i = 1'b0; weight_offset_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // weight offset, single plane, latency of two cycles
        wbits_i = CNT_W'(1); signed_i = 1'b0;
        do_beat(act_all(8'd1), '0, 1'b1, full, 1'b1, "t1");
        #1;
        chk("t1_not_yet_valid", pres_valid_o, 0);
        @(posedge clk_i); #2;
        chk("t1_latency_valid", pres_valid_o, 1);
        chk("t1_data", $signed(pres_data_o), 9);
        @(posedge clk_i); #1;
        expect_result(9, "t1_pop");

        // unsigned w=11, act=3
        pl[0] = '1; pl[1] = '0; pl[2] = '1; pl[3] = '1;
        send_result(act_all(8'd3), pl, CNT_W'(4), 1'b0, full, 1'b0, "t2");
        expect_result(model(act_all(8'd3), pl, CNT_W'(4), 1'b0, full, 1'b0), "t2_297");

        // signed w=-1, act=255
        pl[0] = '1; pl[1] = '1; pl[2] = '1; pl[3] = '1;
        send_result(act_all(8'd255), pl, CNT_W'(4), 1'b1, full, 1'b0, "t3");
        expect_result(-2295, "t3_neg");

        // backpressure: FIFO of two fills, third result waits for a pop
        a1 = 8'($urandom); a2 = 8'($urandom); a3 = 8'($urandom);
        r1 = 9 * longint'(a1); r2 = 9 * longint'(a2); r3 = 9 * longint'(a3);
        wbits_i = CNT_W'(1); signed_i = 1'b0; enable_mask_i = full;
        weight_offset_i = 1'b1; wgt_valid_i = 1'b0; act_valid_i = 1'b1;
        act_data_i = act_all(a1);
        #1; chk("t4_first_ready", wgt_ready_o, 1); chk("t4_first_act_ready", act_ready_o, 1);
        @(posedge clk_i); #1;
        act_data_i = act_all(a2);
        #1; chk("t4_second_ready", wgt_ready_o, 1);
        @(posedge clk_i); #1;
        act_data_i = act_all(a3);
        #1; chk("t4_third_stall_a", wgt_ready_o, 0);
        @(posedge clk_i); #1;
        #1; chk("t4_third_stall_b", wgt_ready_o, 0);
        @(posedge clk_i); #1;
        pres_ready_i = 1'b1;
        #1; chk("t4_stall_during_pop", wgt_ready_o, 0);
        chk("t4_head_r1", $signed(pres_data_o), r1);
        @(posedge clk_i); #1;
        pres_ready_i = 1'b0;
        #1; chk("t4_third_accepted", wgt_ready_o, 1);
        @(posedge clk_i); #1;
        act_valid_i = 1'b0; weight_offset_i = 1'b0;
        expect_result(r2, "t4_r2");
        expect_result(r3, "t4_r3");

        // clear mid-result, then a clean result
        pl[0] = '1; pl[1] = '0; pl[2] = '1; pl[3] = '1;
        wbits_i = CNT_W'(4); signed_i = 1'b0;
        do_beat(act_all(8'd3), pl[0], 1'b0, full, 1'b0, "t5_p0");
        do_beat(act_all(8'd3), pl[1], 1'b0, full, 1'b0, "t5_p1");
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        #1;
        chk("t5_busy_after_clear", busy_o, 0);
        chk("t5_no_result", pres_valid_o, 0);
        @(posedge clk_i); #1;
        #1; chk("t5_still_no_result", pres_valid_o, 0);
        @(posedge clk_i); #1;
        send_result(act_all(8'd3), pl, CNT_W'(4), 1'b0, full, 1'b0, "t5b");
        expect_result(297, "t5_after_clear");

        // enable_i low between planes freezes state, pipe and FIFO
        pl[0] = '1; pl[1] = '1;
        wbits_i = CNT_W'(2); signed_i = 1'b0;
        do_beat(act_all(8'd10), pl[0], 1'b0, 9'h1FE, 1'b0, "t6_p0");
        enable_i = 1'b0; act_valid_i = 1'b1; wgt_valid_i = 1'b1; wgt_data_i = pl[1];
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_frozen_ready", wgt_ready_o, 0);
            chk("t6_frozen_busy", busy_o, 1);
            @(posedge clk_i); #1;
        end
        enable_i = 1'b1;
        do_beat(act_all(8'd10), pl[1], 1'b0, 9'h1FE, 1'b1, "t6_p1");
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("t6_pipe_frozen", pres_valid_o, 0);
            @(posedge clk_i); #1;
        end
        enable_i = 1'b1;
        #1; chk("t6_pipe_draining", pres_valid_o, 0);
        @(posedge clk_i); #1;
        #1; chk("t6_valid", pres_valid_o, 1);
        @(posedge clk_i); #1;
        enable_i = 1'b0; pres_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t6_hold_valid", pres_valid_o, 1);
            chk("t6_hold_data", $signed(pres_data_o), 240);
            @(posedge clk_i); #1;
        end
        pres_ready_i = 1'b0; enable_i = 1'b1;
        expect_result(model(act_all(8'd10), pl, CNT_W'(2), 1'b0, 9'h1FE, 1'b0), "t6_240");

        // randomized back-to-back results with random backpressure
        fork
            begin
                for (int r = 0; r < NRAND; r++) begin
                    act_t             ra;
                    plane_t           rpl[MW];
                    plane_t           rm;
                    logic [CNT_W-1:0] rwb;
                    logic             rsg, roff;
                    for (int ln = 0; ln < CS; ln++) ra[ln*QA +: QA] = QA'($urandom);
                    foreach (rpl[p]) rpl[p] = CS'($urandom);
                    rm   = CS'($urandom);
                    rwb  = CNT_W'($urandom_range(0, 15));
                    rsg  = 1'($urandom);
                    roff = ($urandom_range(0, 7) == 0);
                    exp_q.push_back(model(ra, rpl, rwb, rsg, rm, roff));
                    send_result(ra, rpl, rwb, rsg, rm, roff, $sformatf("rand%0d", r));
                end
            end
            begin
                int got;
                int cyc;
                longint e;
                got = 0;
                cyc = 0;
                while (got < NRAND && cyc < 5000) begin
                    @(posedge clk_i); #1;
                    pres_ready_i = ($urandom_range(0, 3) != 0);
                    #1;
                    if (pres_valid_o === 1'b1 && pres_ready_i) begin
                        e = exp_q.pop_front();
                        chk($sformatf("rand_result%0d", got), $signed(pres_data_o), e);
                        got++;
                    end
                    cyc++;
                end
                chk("rand_all_results", got, NRAND);
                @(posedge clk_i); #1;
                pres_ready_i = 1'b0;
            end
        join

        repeat (3) @(posedge clk_i);
        #1;
        chk("end_idle_busy", busy_o, 0);
        chk("end_no_result", pres_valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
